// File: rtl/aes_pkg.sv
// Shared Rijndael helpers for the round-pipeline stages: legal block widths,
// ShiftRows row offsets, state byte addressing and the skid-buffer occupancy type.
package aes_pkg;

  localparam int NB_LEGAL [3] = '{4, 6, 8};

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  function automatic bit nb_is_legal(input int nb);
    nb_is_legal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (NB_LEGAL[i] == nb) nb_is_legal = 1'b1;
    end
  endfunction

  // 256-bit blocks use offsets 0,1,3,4; the narrower blocks use 0,1,2,3.
  function automatic int shift_off(input int nb, input int r);
    return (nb == 8 && r >= 2) ? r + 1 : r;
  endfunction

  function automatic int byte_lsb(input int r, input int c);
    return c * 32 + r * 8;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
// All column indices are resolved at elaboration, so the mux is pure wiring.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              i_inv,
  input  logic [32*NB-1:0]  i_state,
  output logic [32*NB-1:0]  o_state
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int FWD_COL = (c + shift_off(NB, r)) % NB;
      localparam int INV_COL = (c - shift_off(NB, r) + NB) % NB;

      assign o_state[byte_lsb(r, c) +: 8] = i_inv ? i_state[byte_lsb(r, INV_COL) +: 8]
                                                  : i_state[byte_lsb(r, FWD_COL) +: 8];
    end
  end

endmodule

// File: rtl/shift_rows_unit.sv
// Registered ShiftRows stage: permutes on enqueue into a 2-entry head/skid buffer
// with valid/ready on both sides; in_ready comes only from registered state and rst.
module shift_rows_unit
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [32*NB-1:0]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [32*NB-1:0]  out_state
);

  if (!nb_is_legal(NB)) begin : g_bad_nb
    $error("shift_rows_unit: NB=%0d is not a legal Rijndael block width (4, 6 or 8)", NB);
  end

  occ_t               r_count;
  occ_t               w_count_next;
  logic [32*NB-1:0]   r_head_state;
  logic [TAG_W-1:0]   r_head_tag;
  logic [32*NB-1:0]   r_skid_state;
  logic [TAG_W-1:0]   r_skid_tag;
  logic [32*NB-1:0]   w_perm_state;
  logic               w_push;
  logic               w_pop;
  logic               w_load_head_in;
  logic               w_load_head_skid;
  logic               w_load_skid;

  shift_rows_perm #(.NB(NB)) u_perm (
    .i_inv   (in_inv),
    .i_state (in_state),
    .o_state (w_perm_state)
  );

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_count <= OCC_EMPTY;
    else     r_count <= w_count_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_count_next = r_count;
    unique case (r_count)
      OCC_EMPTY: if (w_push) w_count_next = OCC_ONE;
      OCC_ONE: begin
        if (w_push && !w_pop)      w_count_next = OCC_FULL;
        else if (!w_push && w_pop) w_count_next = OCC_EMPTY;
      end
      OCC_FULL:  if (w_pop) w_count_next = OCC_ONE;
      default:   w_count_next = OCC_EMPTY;
    endcase
  end

  always_comb begin
    in_ready         = !rst && (r_count != OCC_FULL);
    out_valid        = !rst && (r_count != OCC_EMPTY);
    out_state        = rst ? '0 : r_head_state;
    out_tag          = rst ? '0 : r_head_tag;
    w_load_head_in   = 1'b0;
    w_load_head_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_count)
      OCC_EMPTY: w_load_head_in = w_push;
      OCC_ONE: begin
        w_load_head_in = w_push && w_pop;
        w_load_skid    = w_push && !w_pop;
      end
      OCC_FULL:  w_load_head_skid = w_pop;
      default: ;
    endcase
  end

  // NOTE: buffer data is cleared on reset so out_state/out_tag read zero until
  // the first block arrives; this costs a reset mux on every storage bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_state <= '0;
      r_head_tag   <= '0;
      r_skid_state <= '0;
      r_skid_tag   <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head_state <= w_perm_state;
        r_head_tag   <= in_tag;
      end else if (w_load_head_skid) begin
        r_head_state <= r_skid_state;
        r_head_tag   <= r_skid_tag;
      end
      if (w_load_skid) begin
        r_skid_state <= w_perm_state;
        r_skid_tag   <= in_tag;
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_unit.sv
// Bench for shift_rows_unit: NB=4/6/8 instances share one stimulus bus and are
// checked against an array-based ShiftRows reference model.
module tb_shift_rows_unit;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_inv;
  logic [TAG_W-1:0] in_tag;
  logic [255:0]     in_state;
  logic             out_ready;

  logic             in_ready4, in_ready6, in_ready8;
  logic             out_valid4, out_valid6, out_valid8;
  logic [TAG_W-1:0] out_tag4, out_tag6, out_tag8;
  logic [127:0]     out_state4;
  logic [191:0]     out_state6;
  logic [255:0]     out_state8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_rows_unit #(.NB(4), .TAG_W(TAG_W)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_inv(in_inv),
    .in_tag(in_tag), .in_state(in_state[127:0]), .out_valid(out_valid4),
    .out_ready(out_ready), .out_tag(out_tag4), .out_state(out_state4));

  shift_rows_unit #(.NB(6), .TAG_W(TAG_W)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .in_inv(in_inv),
    .in_tag(in_tag), .in_state(in_state[191:0]), .out_valid(out_valid6),
    .out_ready(out_ready), .out_tag(out_tag6), .out_state(out_state6));

  shift_rows_unit #(.NB(8), .TAG_W(TAG_W)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_inv(in_inv),
    .in_tag(in_tag), .in_state(in_state), .out_valid(out_valid8),
    .out_ready(out_ready), .out_tag(out_tag8), .out_state(out_state8));

  // Reference: out(r,c) = in(r, (c +/- s(r)) mod nb) on a 4 x nb byte matrix.
  function automatic logic [255:0] ref_shift(input int nb, input logic inv,
                                              input logic [255:0] s);
    logic [7:0]   m [4][8];
    int           offs [4];
    int           src;
    logic [255:0] res;
    res = '0;
    if (nb == 8) offs = '{0, 1, 3, 4};
    else         offs = '{0, 1, 2, 3};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) m[r][c] = s[c*32 + r*8 +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < nb; c++) begin
        src = inv ? (c - offs[r] + nb) % nb : (c + offs[r]) % nb;
        res[c*32 + r*8 +: 8] = m[r][src];
      end
    return res;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transaction into an empty buffer: push, capture head, pop.
  task automatic xfer(input logic inv, input logic [TAG_W-1:0] tag, input logic [255:0] st,
                      output logic vld, output logic [TAG_W-1:0] tg,
                      output logic [127:0] s4, output logic [191:0] s6, output logic [255:0] s8);
    in_valid = 1'b1; in_inv = inv; in_tag = tag; in_state = st;
    step();
    in_valid = 1'b0;
    vld = out_valid4 & out_valid6 & out_valid8;
    tg = out_tag4; s4 = out_state4; s6 = out_state6; s8 = out_state8;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'hf; in_state = rand256();
    out_ready = 1'b0;
    step(); step();
    total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready4); end
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid4); end
    total++; if (out_state8 !== '0) begin bad++; $display("FAIL reset_out_state got=%h exp=0", out_state8); end
    total++; if (out_tag4 !== '0) begin bad++; $display("FAIL reset_out_tag got=%h exp=0", out_tag4); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", in_ready4); end
    step();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_no_push got=%b exp=0", out_valid4); end
  endtask

  task automatic test_fips_nb4();
    logic [127:0] fips_in  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    logic [127:0] fips_out = 128'he598271ef11141b8ae52b4e0305dbfd4;
    logic [127:0] idx_in   = 128'h0f0e0d0c0b0a09080706050403020100;
    logic [127:0] idx_out  = 128'h0b06010c07020d08030e09040f0a0500;
    logic vld; logic [TAG_W-1:0] tg; logic [127:0] s4; logic [191:0] s6; logic [255:0] s8;
    xfer(1'b0, 4'h5, {128'h0, fips_in}, vld, tg, s4, s6, s8);
    total++; if (vld !== 1'b1) begin bad++; $display("FAIL fips_latency out_valid got=%b exp=1", vld); end
    total++; if (s4 !== fips_out) begin bad++; $display("FAIL fips_fwd got=%h exp=%h", s4, fips_out); end
    total++; if (tg !== 4'h5) begin bad++; $display("FAIL fips_tag got=%h exp=5", tg); end
    xfer(1'b1, 4'h6, {128'h0, fips_out}, vld, tg, s4, s6, s8);
    total++; if (s4 !== fips_in) begin bad++; $display("FAIL fips_inv got=%h exp=%h", s4, fips_in); end
    xfer(1'b0, 4'h7, {128'h0, idx_in}, vld, tg, s4, s6, s8);
    total++; if (s4 !== idx_out) begin bad++; $display("FAIL idx_fwd_nb4 got=%h exp=%h", s4, idx_out); end
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL fips_drained got=%b exp=0", out_valid4); end
  endtask

  task automatic test_nb8();
    logic [255:0] idx, exp_fwd;
    logic vld; logic [TAG_W-1:0] tg; logic [127:0] s4; logic [191:0] s6; logic [255:0] s8, fwd;
    for (int k = 0; k < 32; k++) idx[k*8 +: 8] = 8'(k);
    exp_fwd = ref_shift(8, 1'b0, idx);
    xfer(1'b0, 4'h2, idx, vld, tg, s4, s6, s8);
    fwd = s8;
    total++; if (fwd[0*32 + 2*8 +: 8] !== 8'h0e) begin bad++; $display("FAIL nb8_r2c0 got=%h exp=0e", fwd[0*32 + 2*8 +: 8]); end
    total++; if (fwd[0*32 + 3*8 +: 8] !== 8'h13) begin bad++; $display("FAIL nb8_r3c0 got=%h exp=13", fwd[0*32 + 3*8 +: 8]); end
    total++; if (fwd[7*32 + 1*8 +: 8] !== 8'h01) begin bad++; $display("FAIL nb8_r1c7 got=%h exp=01", fwd[7*32 + 1*8 +: 8]); end
    total++; if (fwd !== exp_fwd) begin bad++; $display("FAIL nb8_fwd got=%h exp=%h", fwd, exp_fwd); end
    xfer(1'b1, 4'h3, fwd, vld, tg, s4, s6, s8);
    total++; if (s8 !== idx) begin bad++; $display("FAIL nb8_inv got=%h exp=%h", s8, idx); end
  endtask

  task automatic test_roundtrip_nb6();
    logic [255:0] x, e;
    logic vld; logic [TAG_W-1:0] tg; logic [127:0] s4; logic [191:0] y6, z6; logic [255:0] s8;
    for (int i = 0; i < 1000; i++) begin
      x = rand256();
      x[255:192] = '0;
      e = ref_shift(6, 1'b0, x);
      xfer(1'b0, 4'(i), x, vld, tg, s4, y6, s8);
      total++; if (y6 !== e[191:0]) begin bad++; $display("FAIL nb6_fwd[%0d] got=%h exp=%h", i, y6, e[191:0]); end
      xfer(1'b1, 4'(i), {64'h0, y6}, vld, tg, s4, z6, s8);
      total++; if (z6 !== x[191:0]) begin bad++; $display("FAIL nb6_roundtrip[%0d] got=%h exp=%h", i, z6, x[191:0]); end
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] a, b, c;
    logic         ia, ib, ic;
    logic [127:0] ea, eb, ec;
    a = rand256(); b = rand256(); c = rand256();
    ia = 1'($urandom); ib = 1'($urandom); ic = 1'($urandom);
    ea = ref_shift(4, ia, a); eb = ref_shift(4, ib, b); ec = ref_shift(4, ic, c);
    out_ready = 1'b0;
    in_valid = 1'b1; in_tag = 4'h1; in_inv = ia; in_state = a;
    step();
    in_tag = 4'h2; in_inv = ib; in_state = b;
    step();
    total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready4); end
    in_tag = 4'h3; in_inv = ic; in_state = c;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL bp_stall_ready[%0d] got=%b exp=0", i, in_ready4); end
      total++; if (out_tag4 !== 4'h1 || out_valid4 !== 1'b1) begin bad++; $display("FAIL bp_stall_tag[%0d] got=%h/%b exp=1/1", i, out_tag4, out_valid4); end
      total++; if (out_state4 !== ea) begin bad++; $display("FAIL bp_stall_state[%0d] got=%h exp=%h", i, out_state4, ea); end
    end
    out_ready = 1'b1;
    step();
    total++; if (out_tag4 !== 4'h2) begin bad++; $display("FAIL bp_second_tag got=%h exp=2", out_tag4); end
    total++; if (out_state4 !== eb) begin bad++; $display("FAIL bp_second_state got=%h exp=%h", out_state4, eb); end
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%b exp=1", in_ready4); end
    step();
    in_valid = 1'b0;
    total++; if (out_tag4 !== 4'h3 || out_valid4 !== 1'b1) begin bad++; $display("FAIL bp_third_tag got=%h/%b exp=3/1", out_tag4, out_valid4); end
    total++; if (out_state4 !== ec) begin bad++; $display("FAIL bp_third_state got=%h exp=%h", out_state4, ec); end
    step();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", out_valid4); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [255:0] st, e4, e8;
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      st = rand256();
      in_valid = 1'b1; in_inv = 1'(i % 2); in_tag = 4'(i); in_state = st;
      e4 = ref_shift(4, in_inv, st);
      e8 = ref_shift(8, in_inv, st);
      total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready4); end
      step();
      total++; if (out_valid4 !== 1'b1 || out_tag4 !== 4'(i)) begin bad++; $display("FAIL stream_tag[%0d] got=%h/%b exp=%h/1", i, out_tag4, out_valid4, 4'(i)); end
      total++; if (out_state4 !== e4[127:0]) begin bad++; $display("FAIL stream_nb4[%0d] got=%h exp=%h", i, out_state4, e4[127:0]); end
      total++; if (out_state8 !== e8) begin bad++; $display("FAIL stream_nb8[%0d] got=%h exp=%h", i, out_state8, e8); end
    end
    in_valid = 1'b0;
    step();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL stream_drained got=%b exp=0", out_valid4); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_full();
    logic [127:0] e;
    out_ready = 1'b0;
    in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'h8; in_state = rand256();
    step();
    in_tag = 4'h9; in_state = rand256();
    step();
    total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL rstfull_precond got=%b exp=0", in_ready4); end
    rst = 1'b1;
    #1;
    total++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b0) begin bad++; $display("FAIL rstfull_comb got=%b/%b exp=0/0", out_valid4, in_ready4); end
    total++; if (out_state4 !== '0) begin bad++; $display("FAIL rstfull_state got=%h exp=0", out_state4); end
    step();
    rst = 1'b0;
    #1;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rstfull_valid got=%b exp=0", out_valid4); end
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL rstfull_ready got=%b exp=1", in_ready4); end
    total++; if (out_state4 !== '0 || out_tag4 !== '0) begin bad++; $display("FAIL rstfull_cleared got=%h/%h exp=0/0", out_state4, out_tag4); end
    in_tag = 4'ha; in_inv = 1'b1; in_state = rand256();
    e = ref_shift(4, 1'b1, in_state);
    step();
    in_valid = 1'b0;
    total++; if (out_valid4 !== 1'b1 || out_tag4 !== 4'ha) begin bad++; $display("FAIL rstfull_first_push got=%h/%b exp=a/1", out_tag4, out_valid4); end
    total++; if (out_state4 !== e) begin bad++; $display("FAIL rstfull_first_state got=%h exp=%h", out_state4, e); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rstfull_drained got=%b exp=0", out_valid4); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fips_nb4();
    test_nb8();
    test_roundtrip_nb6();
    test_backpressure();
    test_back_to_back();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_rows_unit.md
# shift_rows_unit

Registered, parametrised ShiftRows/InvShiftRows stage for the Rijndael datapath, selectable per transaction. Supports block widths of 4, 6 or 8 columns (128/192/256-bit state) with the Rijndael row offsets for each. Sits between the SubBytes and MixColumns stages of the round pipeline, with a valid/ready handshake on both sides, a sideband tag, and a 2-entry skid buffer so it sustains one block per cycle under backpressure.

## Interface
- NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration-time $error
- TAG_W, 4, sideband tag width (≥1), passed through unmodified
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input block present
- in_ready  out  1  unit accepts input this cycle
- in_inv  in  1  0 = forward ShiftRows, 1 = InvShiftRows
- in_tag  in  TAG_W  sideband, travels with the block
- in_state  in  32*NB  state; byte (r,c) at bits [c*32 + r*8 +: 8] (byte k of a FIPS string at [8k +: 8])
- out_valid  out  1  output block present
- out_ready  in  1  downstream accepts output
- out_tag  out  TAG_W  tag of head block
- out_state  out  32*NB  permuted state of head block

## Operation
- Row offsets s(r): NB=4 or 6 → 0,1,2,3; NB=8 → 0,1,3,4.
- Forward: out(r,c) = in(r, (c + s(r)) mod NB). Inverse: out(r,c) = in(r, (c − s(r) + NB) mod NB). Index arithmetic is in integers; no out-of-range column is ever addressed.
- Permutation is applied combinationally on in_state at enqueue; the buffer stores permuted data and the tag only (mode bit is not stored).
- Storage: head register H (drives out_*) and skid register S; occupancy count ∈ {0,1,2} (states EMPTY, ONE, FULL).
- Push = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY: push → H, go ONE.
- ONE: push only → S, go FULL; pop only → EMPTY; push & pop → H replaced by new block, stay ONE.
- FULL: pop → S moves to H, go ONE; push impossible (in_ready=0).
- Strict FIFO order; no block dropped or duplicated; out_* held stable while out_valid & !out_ready.
- in_ready = !rst & (count != 2); out_valid = (count != 0).

## Timing
- Reset (rst high at an edge): count ← 0, H and S data/tag ← 0. While rst high: in_ready=0, out_valid=0, out_state=0, out_tag=0; inputs ignored.
- Reset mid-operation discards all buffered blocks; first push allowed in the cycle rst is low.
- Latency: block pushed at edge k appears on out_* with out_valid=1 after edge k (visible cycle k+1).
- Throughput: 1 block/cycle with out_ready held high (ONE state with push & pop every cycle).
- Backpressure: after out_ready drops, at most one more block is accepted (into S); in_ready falls the cycle after count reaches 2 and rises the cycle after the pop from FULL.
- in_ready depends only on registered state and rst, never on out_ready (no combinational ready path).

## Structure
- aes_pkg: function shift_off(nb, r), function byte_lsb(r, c) = c*32 + r*8, localparam list of legal NB values; shared with mix_columns/sub_bytes stages.
- Sub-module shift_rows_perm (combinational, params NB, input inv, state in/out) holding the generate-loop permutation; shift_rows_unit instantiates it once and adds the buffer/handshake.

## Test plan
- NB=4 forward, FIPS-197 B round 1: in d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 → out d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, out_valid one cycle after push.
- NB=4 inverse: feed that output with in_inv=1 → original string; byte k = k input forward → out col0 00 05 0a 0f, col1 04 09 0e 03, col2 08 0d 02 07, col3 0c 01 06 0b.
- NB=8 forward, byte k = k (00..1f): out(2,0)=0x0e, out(3,0)=0x13, out(1,7)=0x01; inverse of result restores input; NB=6 round-trip random 1000 blocks.
- Backpressure: push tags 1,2,3 every cycle with out_ready=0 → only 1,2 accepted, in_ready=0 next cycle; release out_ready → tags 1,2,3 emerge in order, outputs stable while stalled.
- Streaming: out_ready=1, 64 back-to-back pushes alternating in_inv → 64 outputs on consecutive cycles, each matching reference model.
- Reset with count=2 → next cycle out_valid=0, in_ready=1 after rst low, out_state=0; NB=5 fails elaboration.
